if_fetch_unit: RTL and testbench

Parametrised multi-issue instruction fetch stage. It issues aligned fetch-bundle addresses to instruction memory and captures FETCH_WIDTH instructions per response. Captured bundles go into an internal bundle FIFO that decouples the stage from the IF/ID queue. The FIFO also absorbs downstream stalls and FREEZE without losing in-flight data. Branch redirects flush all younger fetch state and restart at any word-aligned address.

---
 rtl/if_pkg.sv | 36 +++
 rtl/if_bundle_fifo.sv | 52 +++++
 rtl/if_fetch_unit.sv | 132 +++++++++++++
 tb/tb_if_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction fetch stage.
//   BA / OFF_W   : bundle size in bytes and lane-offset width for the default
//                  two-wide configuration
//   if_state_e   : fetch controller states
//   lane_mask()  : per-lane valid bits for a given word offset in a bundle
//   if_bundle_t  : bundle record layout {instr, pc, mask} (default widths)
package if_pkg;

  localparam int FETCH_WIDTH_DEF = 2;
  localparam int MAX_FW          = 8;
  localparam int BA              = FETCH_WIDTH_DEF * 4;
  localparam int OFF_W           = $clog2(FETCH_WIDTH_DEF);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [FETCH_WIDTH_DEF*32-1:0] instr;
    logic [31:0]                   pc;
    logic [FETCH_WIDTH_DEF-1:0]    mask;
  } if_bundle_t;

  // Lanes below the entry offset precede the fetch PC and are invalid.
  function automatic logic [MAX_FW-1:0] lane_mask(input int unsigned off,
                                                  input int unsigned fw);
    logic [MAX_FW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_FW; i++)
      m[i] = (i >= off) && (i < fw);
    return m;
  endfunction

endpackage

// File: rtl/if_bundle_fifo.sv
// First-word-fall-through bundle FIFO.
//   CLK, RESET : clock, async active-low reset (storage cleared too)
//   clr        : synchronous flush, wins over push/pop
//   push/wdata : write an entry (caller guarantees space)
//   pop        : drop the head entry (caller guarantees non-empty)
//   rdata      : current head entry
//   count      : number of valid entries
module if_bundle_fifo
  #(parameter int DATA_W = 8,
    parameter int DEPTH  = 4)
  (input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     clr,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        wdata,
   output logic [DATA_W-1:0]        rdata,
   output logic [$clog2(DEPTH):0]   count);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Multi-issue instruction fetch stage.
//   CLK, RESET         : clock, async active-low reset
//   FREEZE             : blocks new requests and pushes (captures continue)
//   PC_init            : start address loaded while RESET is low
//   redirect_valid/addr: flush and restart at a word-aligned target
//   Instr_address_2IM  : bundle-aligned fetch address, im_req strobe
//   Instr_fIM          : IM data, one cycle after the request, lane 0 in LSBs
//   bundle_*           : head of the bundle FIFO
//   tQ_IFID_pushReq    : pushes the head into IF/ID (pops it here)
//   tQ_IFID_full       : IF/ID back-pressure
//
// state | meaning
// RUN   | requests allowed
// HOLD  | FIFO space fully reserved or FREEZE high
// FLUSH | one cycle after a redirect, nothing captured
module if_fetch_unit
  import if_pkg::*;
  #(parameter int FETCH_WIDTH = 2,
    parameter int INSTR_W     = 32,
    parameter int ADDR_W      = 32,
    parameter int BUF_DEPTH   = 4)
  (input  logic                           CLK,
   input  logic                           RESET,
   input  logic                           FREEZE,
   input  logic [ADDR_W-1:0]              PC_init,
   input  logic                           redirect_valid,
   input  logic [ADDR_W-1:0]              redirect_addr,
   output logic [ADDR_W-1:0]              Instr_address_2IM,
   output logic                           im_req,
   input  logic [FETCH_WIDTH*INSTR_W-1:0] Instr_fIM,
   output logic [FETCH_WIDTH*INSTR_W-1:0] bundle_instr,
   output logic [ADDR_W-1:0]              bundle_pc,
   output logic [FETCH_WIDTH-1:0]         bundle_mask,
   output logic                           tQ_IFID_pushReq,
   input  logic                           tQ_IFID_full);

  localparam int BA_B    = FETCH_WIDTH * 4;
  localparam int LANES_W = FETCH_WIDTH * INSTR_W;
  localparam int ENTRY_W = LANES_W + ADDR_W + FETCH_WIDTH;
  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(BA_B - 1);
  localparam logic [CNT_W:0]    DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);

  logic [ADDR_W-1:0]      pc_q;
  logic [ADDR_W-1:0]      pc_aligned;
  logic [ADDR_W-1:0]      req_pc_q;
  logic [FETCH_WIDTH-1:0] mask_now;
  logic [FETCH_WIDTH-1:0] req_mask_q;
  logic                   inflight_q;
  logic                   has_space;
  logic                   capture;
  logic                   pop;
  logic [CNT_W-1:0]       count;
  logic [LANES_W-1:0]     instr_masked;
  logic [ENTRY_W-1:0]     wr_entry;
  logic [ENTRY_W-1:0]     head;
  if_state_e              state_q;
  if_state_e              state_d;

  assign pc_aligned        = pc_q & ~LOW_MASK;
  assign Instr_address_2IM = pc_aligned;
  assign mask_now = FETCH_WIDTH'(lane_mask(32'((pc_q & LOW_MASK) >> 2), FETCH_WIDTH));

  // Occupancy includes the in-flight response so a capture always has room.
  assign has_space = ({1'b0, count} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C;

  // RESET gating keeps the strobe low while the inputs are still live in reset.
  assign im_req  = RESET && !FREEZE && !redirect_valid && has_space;
  assign pop     = (count != '0) && !tQ_IFID_full && !FREEZE && !redirect_valid;
  assign capture = inflight_q && !redirect_valid && (state_q != FLUSH);
  assign tQ_IFID_pushReq = pop;

  always_comb begin
    instr_masked = '0;
    for (int i = 0; i < FETCH_WIDTH; i++)
      if (req_mask_q[i]) instr_masked[i*INSTR_W +: INSTR_W] = Instr_fIM[i*INSTR_W +: INSTR_W];
  end

  assign wr_entry = {instr_masked, req_pc_q, req_mask_q};

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q       <= PC_init;
      req_pc_q   <= '0;
      req_mask_q <= '0;
      inflight_q <= 1'b0;
      state_q    <= RUN;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q       <= redirect_addr;
        inflight_q <= 1'b0;
      end else if (im_req) begin
        pc_q       <= pc_aligned + ADDR_W'(BA_B);
        req_pc_q   <= pc_aligned;
        req_mask_q <= mask_now;
        inflight_q <= 1'b1;
      end else if (capture) begin
        inflight_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FLUSH;
    end else begin
      case (state_q)
        RUN, FLUSH: state_d = (FREEZE || !has_space) ? HOLD : RUN;
        HOLD:       state_d = (!FREEZE && has_space) ? RUN : HOLD;
        default:    state_d = RUN;
      endcase
    end
  end

  if_bundle_fifo #(.DATA_W(ENTRY_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (redirect_valid),
    .push  (capture),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (head),
    .count (count)
  );

  assign bundle_mask  = head[FETCH_WIDTH-1:0];
  assign bundle_pc    = head[FETCH_WIDTH +: ADDR_W];
  assign bundle_instr = head[FETCH_WIDTH+ADDR_W +: LANES_W];

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import if_pkg::*;

  localparam int FW    = 2;
  localparam int IW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          FREEZE;
  logic [AW-1:0] PC_init;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] Instr_address_2IM;
  logic          im_req;
  logic [FW*IW-1:0] Instr_fIM;
  logic [FW*IW-1:0] bundle_instr;
  logic [AW-1:0] bundle_pc;
  logic [FW-1:0] bundle_mask;
  logic          tQ_IFID_pushReq;
  logic          tQ_IFID_full;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: buffered bundles, the outstanding request, the fetch PC.
  if_bundle_t    q[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_infl_pc;
  bit            m_infl;

  always #5 CLK = ~CLK;

  if_fetch_unit #(.FETCH_WIDTH(FW), .INSTR_W(IW), .ADDR_W(AW), .BUF_DEPTH(DEPTH)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .FREEZE            (FREEZE),
    .PC_init           (PC_init),
    .redirect_valid    (redirect_valid),
    .redirect_addr     (redirect_addr),
    .Instr_address_2IM (Instr_address_2IM),
    .im_req            (im_req),
    .Instr_fIM         (Instr_fIM),
    .bundle_instr      (bundle_instr),
    .bundle_pc         (bundle_pc),
    .bundle_mask       (bundle_mask),
    .tQ_IFID_pushReq   (tQ_IFID_pushReq),
    .tQ_IFID_full      (tQ_IFID_full)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] imw(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return a & ~AW'(BA - 1);
  endfunction

  function automatic logic [FW*IW-1:0] im_data(input logic [AW-1:0] a);
    logic [FW*IW-1:0] d;
    for (int i = 0; i < FW; i++) d[i*IW +: IW] = imw(align(a) + AW'(4*i));
    return d;
  endfunction

  function automatic if_bundle_t make_bundle(input logic [AW-1:0] pc);
    if_bundle_t b;
    int off;
    b.pc    = align(pc);
    b.instr = '0;
    b.mask  = '0;
    off     = int'(pc[OFF_W+1:2]);
    for (int i = 0; i < FW; i++)
      if (i >= off) begin
        b.mask[i]          = 1'b1;
        b.instr[i*IW +: IW] = imw(b.pc + AW'(4*i));
      end
    return b;
  endfunction

  task automatic step(input bit frz, input bit rdv, input logic [AW-1:0] rda, input bit full);
    bit exp_req;
    bit exp_push;
    @(negedge CLK);
    FREEZE         = frz;
    redirect_valid = rdv;
    redirect_addr  = rda;
    tQ_IFID_full   = full;
    Instr_fIM      = m_infl ? im_data(m_infl_pc) : {$urandom, $urandom};
    #1;
    exp_req  = !frz && !rdv && (q.size() + int'(m_infl) < DEPTH);
    exp_push = (q.size() != 0) && !full && !frz && !rdv;
    chk("addr",   64'(Instr_address_2IM), 64'(align(m_pc)));
    chk("im_req", 64'(im_req),            64'(exp_req));
    chk("push",   64'(tQ_IFID_pushReq),   64'(exp_push));
    if (q.size() != 0) begin
      chk("head_pc",    64'(bundle_pc),    64'(q[0].pc));
      chk("head_mask",  64'(bundle_mask),  64'(q[0].mask));
      chk("head_instr", 64'(bundle_instr), 64'(q[0].instr));
    end
    @(posedge CLK);
    if (rdv) begin
      q.delete();
      m_infl = 1'b0;
      m_pc   = rda;
    end else begin
      if (exp_push) void'(q.pop_front());
      if (m_infl) q.push_back(make_bundle(m_infl_pc));
      m_infl = exp_req;
      if (exp_req) begin
        m_infl_pc = m_pc;
        m_pc      = align(m_pc) + AW'(BA);
      end
    end
  endtask

  // Asserts reset mid-cycle so the asynchronous path is what gets observed.
  task automatic do_reset(input logic [AW-1:0] pci);
    @(negedge CLK);
    #2;
    PC_init        = pci;
    FREEZE         = 1'b0;
    redirect_valid = 1'b0;
    tQ_IFID_full   = 1'b0;
    RESET          = 1'b0;
    #1;
    chk("rst_im_req", 64'(im_req),            64'(0));
    chk("rst_push",   64'(tQ_IFID_pushReq),   64'(0));
    chk("rst_instr",  64'(bundle_instr),      64'(0));
    chk("rst_pc",     64'(bundle_pc),         64'(0));
    chk("rst_mask",   64'(bundle_mask),       64'(0));
    chk("rst_addr",   64'(Instr_address_2IM), 64'(align(pci)));
    q.delete();
    m_infl = 1'b0;
    m_pc   = pci;
    @(posedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    RESET = 1'b0; FREEZE = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
    tQ_IFID_full = 1'b0; PC_init = 32'h100; Instr_fIM = '0;
    m_pc = '0; m_infl_pc = '0; m_infl = 1'b0;

    // streaming from 0x100
    do_reset(32'h100);
    repeat (6) step(0, 0, '0, 0);

    // IF/ID full from the start, then drain
    do_reset(32'h100);
    repeat (8) step(0, 0, '0, 1);
    repeat (8) step(0, 0, '0, 0);

    // redirect with 3 buffered + 1 in flight
    do_reset(32'h100);
    repeat (4) step(0, 0, '0, 1);
    step(0, 1, 32'h204, 1);
    repeat (5) step(0, 0, '0, 0);

    // freeze right after a request, then redirect while frozen
    step(0, 0, '0, 0);
    repeat (3) step(1, 0, '0, 0);
    repeat (3) step(0, 0, '0, 0);
    step(1, 1, 32'h3F4, 0);
    step(1, 0, '0, 0);
    repeat (4) step(0, 0, '0, 0);

    // address wrap
    do_reset(32'hFFFF_FFF8);
    repeat (5) step(0, 0, '0, 0);

    // reset mid-stream with 2 bundles buffered
    do_reset(32'h100);
    repeat (3) step(0, 0, '0, 1);
    do_reset(32'h44);
    repeat (5) step(0, 0, '0, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        ra = 32'hFFFF_FFE0 | (32'($urandom_range(0, 7)) << 2);
      else
        ra = 32'($urandom_range(0, 4095)) << 2;
      if ($urandom_range(0, 499) == 0)
        do_reset({$urandom} & ~32'h3);
      step($urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, ra,
           $urandom_range(0, 2) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
